// File: rtl/sub_serial.sv
// sub_serial: bit-serial N-bit subtractor/comparator, LSB first.
// Loads A, B and a borrow-in on start, then resolves one bit per clock
// through a single full-subtractor cell with the borrow held in a flop.
// Q, C_wy (A < B + C_we) and Z (Q == 0) are registered on the edge that
// enters DONE and held until the next completion.
// Optional: define SUB_SERIAL_SIGNED_EN to add the signed outputs V
// (two's-complement overflow) and LT_s (signed A < B).
module sub_serial #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_we,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic         C_wy,
    output logic         Z
`ifdef SUB_SERIAL_SIGNED_EN
    ,
    output logic         V,
    output logic         LT_s
`endif
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic          borrow;
    logic [CW-1:0] cnt;
    logic [N-1:0]  res;

    logic          d_bit;
    logic          borrow_nxt;
    logic [N-1:0]  res_nxt;
    logic          last_bit;
    logic          accept;

    // Full-subtractor cell on the current LSBs, plus the next result word.
    always_comb begin
        d_bit      = sa[0] ^ sb[0] ^ borrow;
        borrow_nxt = (sb[0] & borrow) | (~sa[0] & (sb[0] ^ borrow));
        res_nxt    = {d_bit, res[N-1:1]};
        last_bit   = (cnt == CW'(N - 1));
        // start is honoured in IDLE and in DONE (back-to-back), never in SHIFT
        accept     = start & ((state == ST_IDLE) | (state == ST_DONE));
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    // Control FSM and serial datapath: load on accept, shift one bit per clock.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            res    <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= borrow_nxt;
                    res    <= res_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) state <= ST_DONE;
                end
                default: begin
                    if (accept) begin
                        sa     <= A;
                        sb     <= B;
                        borrow <= C_we;
                        cnt    <= '0;
                        state  <= ST_SHIFT;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Result registers: captured only on the edge that resolves the MSB.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Q    <= '0;
            C_wy <= 1'b0;
            Z    <= 1'b0;
        end else if (busy && last_bit) begin
            Q    <= res_nxt;
            C_wy <= borrow_nxt;
            Z    <= (res_nxt == '0);
        end
    end

`ifdef SUB_SERIAL_SIGNED_EN
    // Operand sign bits are shifted out of sa/sb, so keep a copy at load.
    logic a_msb;
    logic b_msb;
    logic v_nxt;

    assign v_nxt = (a_msb ^ b_msb) & (a_msb ^ res_nxt[N-1]);

    // Latch operand MSBs at load time.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            a_msb <= A[N-1];
            b_msb <= B[N-1];
        end
    end

    // Signed flags, updated together with Q.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            V    <= 1'b0;
            LT_s <= 1'b0;
        end else if (busy && last_bit) begin
            V    <= v_nxt;
            LT_s <= res_nxt[N-1] ^ v_nxt;
        end
    end
`else
    // Unsigned-only build: comparison is available through C_wy alone.
`endif

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed + random checks of sub_serial against an
// arithmetic model (A - B - C_we mod 2^N, unsigned borrow, zero flag).
module tb_sub_serial;

    localparam int N = 8;

    logic         CLK;
    logic         RST_n;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C_we;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic         C_wy;
    logic         Z;
`ifdef SUB_SERIAL_SIGNED_EN
    logic         V;
    logic         LT_s;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // expected results of the operation in flight, and of the previous one
    logic [N-1:0] exp_q,  prev_q;
    logic         exp_c,  prev_c;
    logic         exp_z,  prev_z;
    logic         exp_v,  prev_v;
    logic         exp_lt, prev_lt;

    sub_serial #(.N(N)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C_we  (C_we),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .C_wy  (C_wy),
        .Z     (Z)
`ifdef SUB_SERIAL_SIGNED_EN
        ,
        .V     (V),
        .LT_s  (LT_s)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        int diff;
        prev_q  = exp_q;  prev_c = exp_c;  prev_z = exp_z;
        prev_v  = exp_v;  prev_lt = exp_lt;
        diff    = int'(a) - int'(b) - int'(c);
        exp_q   = N'(diff);
        exp_c   = (int'(a) < int'(b) + int'(c));
        exp_z   = (exp_q == '0);
        exp_v   = (a[N-1] ^ b[N-1]) & (a[N-1] ^ exp_q[N-1]);
        exp_lt  = exp_q[N-1] ^ exp_v;
    endtask

    // Present operands with start for one edge. If now_ok, drive at once
    // (used from the DONE cycle for back-to-back starts).
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                            input bit now_ok);
        if (!now_ok) @(negedge CLK);
        A = a; B = b; C_we = c; start = 1'b1;
        model(a, b, c);
        @(posedge CLK); #1;
        start = 1'b0;
        // operands are free to change after the start edge
        A = N'($urandom); B = N'($urandom); C_we = 1'($urandom);
    endtask

    // Walk the N SHIFT cycles, then check the DONE cycle results.
    // inj >= 0 pulses a (to be ignored) start during that bit.
    task automatic finish_op(input string tag, input int inj);
        int busy_bad = 0;
        int hold_bad = 0;
        for (int i = 0; i < N; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            if (Q !== prev_q || C_wy !== prev_c || Z !== prev_z) hold_bad++;
            if (i == inj) begin
                A = '1; B = '0; C_we = 1'b0; start = 1'b1;
            end
            @(posedge CLK); #1;
            start = 1'b0;
        end
        check({tag, ".busy_cycles"}, busy_bad, 0);
        check({tag, ".hold"},        hold_bad, 0);
        check({tag, ".done"},        {busy, done}, 2'b01);
        check({tag, ".Q"},           Q, exp_q);
        check({tag, ".C_wy"},        C_wy, exp_c);
        check({tag, ".Z"},           Z, exp_z);
`ifdef SUB_SERIAL_SIGNED_EN
        check({tag, ".V"},           V, exp_v);
        check({tag, ".LT_s"},        LT_s, exp_lt);
`endif
        prev_q = exp_q; prev_c = exp_c; prev_z = exp_z; prev_v = exp_v; prev_lt = exp_lt;
    endtask

    // done must drop after one cycle while results hold.
    task automatic check_after_done(input string tag);
        @(posedge CLK); #1;
        check({tag, ".idle"}, {busy, done}, 2'b00);
        check({tag, ".Qhold"}, {Q, C_wy, Z}, {exp_q, exp_c, exp_z});
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        exp_q = '0; exp_c = 1'b0; exp_z = 1'b0; exp_v = 1'b0; exp_lt = 1'b0;
        prev_q = '0; prev_c = 1'b0; prev_z = 1'b0; prev_v = 1'b0; prev_lt = 1'b0;
        RST_n = 1'b0; start = 1'b0; A = '0; B = '0; C_we = 1'b0;

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        check("reset.outs", {busy, done, Q, C_wy, Z}, '0);
        @(negedge CLK); RST_n = 1'b1;
        @(posedge CLK); #1;
        check("idle.nostart", {busy, done}, 2'b00);

        // basic cases
        start_op(8'h35, 8'h12, 1'b0, 0); finish_op("t35_12", -1); check_after_done("t35_12");
        start_op(8'h12, 8'h35, 1'b0, 0); finish_op("t12_35", -1); check_after_done("t12_35");
        start_op(8'h5A, 8'h5A, 1'b0, 0); finish_op("eq_c0",  -1); check_after_done("eq_c0");
        start_op(8'h5A, 8'h5A, 1'b1, 0); finish_op("eq_c1",  -1); check_after_done("eq_c1");
        start_op(8'h00, 8'h00, 1'b1, 0); finish_op("zero_c1", -1);
        start_op(8'hFF, 8'hFF, 1'b0, 0); finish_op("ff_ff",  -1);

        // start during bit 3 is ignored
        start_op(8'h35, 8'h12, 1'b0, 0); finish_op("ignore", 3); check_after_done("ignore");

        // reset during bit 4
        start_op(8'hC3, 8'h3C, 1'b0, 0);
        repeat (4) @(posedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        check("midrst.outs", {busy, done, Q, C_wy, Z}, '0);
`ifdef SUB_SERIAL_SIGNED_EN
        check("midrst.sgn", {V, LT_s}, 2'b00);
`endif
        @(negedge CLK); RST_n = 1'b1;
        @(posedge CLK); #1;
        check("midrst.idle", {busy, done}, 2'b00);
        exp_q = '0; exp_c = 1'b0; exp_z = 1'b0; exp_v = 1'b0; exp_lt = 1'b0;
        start_op(8'h35, 8'h12, 1'b0, 0); finish_op("postrst", -1);

        // back-to-back: start asserted in the DONE cycle
        start_op(8'h01, 8'h02, 1'b0, 1);
        finish_op("b2b", -1); check_after_done("b2b");

`ifdef SUB_SERIAL_SIGNED_EN
        start_op(8'h80, 8'h01, 1'b0, 0); finish_op("s80_01", -1);
        start_op(8'h05, 8'h03, 1'b0, 0); finish_op("s05_03", -1);
`endif

        // random operations, some back-to-back
        for (int k = 0; k < 24; k++) begin
            ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
            if (k % 5 == 0) rb = ra;
            start_op(ra, rb, rc, (k % 3 == 1));
            finish_op($sformatf("rnd%0d", k), (k % 4 == 2) ? int'($urandom_range(0, N - 1)) : -1);
        end
        check_after_done("rnd_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
Bit-serial N-bit subtractor/comparator built around the 1-bit full-subtractor cell used in the comparator/counter chain. It loads two N-bit operands and a borrow-in on a start request. It then processes one bit per clock, LSB first, keeping the borrow in a flip-flop, and presents the difference, final borrow and a zero flag. The block sits directly downstream of the operand registers and feeds the comparator/counter control that consumes C_wy (A<B) and Z (A==B).

Parameters:
N, 8, operand/result width in bits; legal range 2..32.

Ports:
CLK  input  1  clock, rising edge active
RST_n  input  1  asynchronous reset, active low
start  input  1  request to load operands and begin; sampled on CLK rise
A  input  N  minuend, sampled only on an accepted start
B  input  N  subtrahend, sampled only on an accepted start
C_we  input  1  borrow-in, sampled only on an accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: results valid from this cycle on
Q  output  N  difference A - B - C_we mod 2^N
C_wy  output  1  final borrow out (1 = A < B + C_we, unsigned)
Z  output  1  1 when Q == 0

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_n is asynchronous and active-low.
- RST_n low, at any time including mid-operation:
  - state = IDLE; operand shift regs, borrow FF, bit counter and result shift reg cleared.
  - busy = 0, done = 0, Q = 0, C_wy = 0, Z = 0.
  - Release is synchronous to the next CLK rise.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at edge k: load sa=A, sb=B, borrow=C_we, cnt=0; go to SHIFT.
  - start = 0: stay in IDLE.
- SHIFT, edges k+1 .. k+N (bit i = cnt):
  - d = sa[0] ^ sb[0] ^ borrow.
  - borrow' = (sb[0] & borrow) | (~sa[0] & (sb[0] ^ borrow)).
  - d shifted into result-reg MSB, result reg shifted right.
  - sa and sb shifted right; cnt++.
  - On the edge processing bit N-1 (edge k+N):
    - Q <= final result reg; C_wy <= final borrow; Z <= (final result == 0).
    - Go to DONE.
- DONE:
  - Lasts exactly one cycle; done = 1.
  - start = 1: accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Timing:
  - busy = 1 exactly in state SHIFT, i.e. N cycles.
  - Latency from start edge to done: N+1 cycles.
- Outputs:
  - Q, C_wy and Z are registered.
  - They change only on the edge entering DONE (or on reset) and hold until the next completion.
- start while busy (SHIFT) is ignored; no queuing, and the operation in progress is unaffected.
- A, B and C_we may change freely after the start edge.
- Wrap-around: the difference is modulo 2^N; the borrow is reported only via C_wy.
- Z reports a zero difference; with C_we = 0 it equals A == B.

Optional Feature:
- Macro: SUB_SERIAL_SIGNED_EN.
- Defined: two extra outputs, V (1 bit, two's-complement overflow) and LT_s (1 bit, signed A < B).
  - V = (A[N-1] ^ B[N-1]) & (A[N-1] ^ Q[N-1]), using the latched operand MSBs.
  - LT_s = Q[N-1] ^ V.
  - Both registered, updated with Q, reset to 0.
- Undefined: the ports V and LT_s do not exist; only unsigned compare via C_wy.

Test Plan:
- N=8, A=0x35, B=0x12, C_we=0, start at edge k -> busy for 8 cycles; done at cycle k+9 with Q=0x23, C_wy=0, Z=0.
- A=0x12, B=0x35, C_we=0 -> Q=0xDD, C_wy=1, Z=0.
- A=B=0x5A, C_we=0 -> Q=0x00, C_wy=0, Z=1. Repeat with C_we=1 -> Q=0xFF, C_wy=1, Z=0.
- Start 0x35/0x12, then pulse start with A=0xFF, B=0x00 on bit 3 -> ignored, result still 0x23. Next op: assert RST_n=0 during bit 4 -> all outputs 0 immediately, state IDLE; a fresh start afterwards yields the correct result.
- start held high through the done cycle with new operands A=0x01, B=0x02 -> second op accepted with no idle gap; Q=0xFF, C_wy=1 after a further N+1 cycles.
- SUB_SERIAL_SIGNED_EN defined, A=0x80, B=0x01 -> Q=0x7F, C_wy=0, V=1, LT_s=1. A=0x05, B=0x03 -> V=0, LT_s=0.
